// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the core memory port arbiter
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arb_sel.sv
// rtl/mem_arb_sel.sv - combinational IF/D winner select; MEM_ARB_RR_EN selects round-robin
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       starved,
  input  req_id_t    last_owner,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
  logic unused_starved;
  assign unused_starved = starved;
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  // One-hot winner; ties go to the policy, single requests always win
  always_comb begin
    gnt = '0;
    if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      if (last_owner == REQ_D) gnt[REQ_IF] = 1'b1;
      else                     gnt[REQ_D]  = 1'b1;
`else
      if (starved) gnt[REQ_IF] = 1'b1;
      else         gnt[REQ_D]  = 1'b1;
`endif
    end else if (if_req) begin
      gnt[REQ_IF] = 1'b1;
    end else if (d_req) begin
      gnt[REQ_D] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory port between IF and D; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [STRB_W-1:0] d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SC_W = $clog2(MAX_WAIT + 1);
  localparam int LC_W = $clog2(READ_LATENCY + 1);

  state_t          state, state_nxt;
  req_id_t         owner;
  req_id_t         last_owner;
  logic            is_write;
  logic [LC_W-1:0] lat_cnt;
  logic [SC_W-1:0] starve_cnt;
  logic [1:0]      sel_gnt;
  logic            starved;
  logic            rd_done;

  assign starved = (starve_cnt == SC_W'(MAX_WAIT));
  assign rd_done = (lat_cnt == LC_W'(READ_LATENCY));

  mem_arb_sel u_sel (
    .if_req     (if_req),
    .d_req      (d_req),
    .starved    (starved),
    .last_owner (last_owner),
    .gnt        (sel_gnt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, grants and completion pulses; grants only ever leave IDLE
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    case (state)
      IDLE: begin
        if_gnt = sel_gnt[REQ_IF];
        d_gnt  = sel_gnt[REQ_D];
        if (|sel_gnt) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (is_write) begin
          d_rvalid  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (rd_done) begin
          if (owner == REQ_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner's request into the memory port; strobes live for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= '0;
      owner      <= REQ_IF;
      is_write   <= 1'b0;
      last_owner <= REQ_D;
    end else begin
      mem_we <= '0;
      if (if_gnt) begin
        mem_addr   <= if_addr;
        owner      <= REQ_IF;
        is_write   <= 1'b0;
        last_owner <= REQ_IF;
      end else if (d_gnt) begin
        mem_addr   <= d_addr;
        mem_wdata  <= d_wdata;
        mem_we     <= d_we;
        owner      <= REQ_D;
        is_write   <= |d_we;
        last_owner <= REQ_D;
      end
    end
  end

  // Read latency counter: 1 in the first WAIT cycle, data due when it reaches READ_LATENCY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (state == ACCESS && !is_write) begin
      lat_cnt <= LC_W'(1);
    end else if (state == WAIT) begin
      lat_cnt <= rd_done ? '0 : lat_cnt + LC_W'(1);
    end
  end

  // Fetch starvation guard: counts IF losses to D, cleared by any IF grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && if_req && !starved) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

`ifndef SYNTHESIS
  a_if_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (if_req && !if_gnt) |=> (!if_req || $stable(if_addr)));
  a_d_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (d_req && !d_gnt) |=> (!d_req || $stable({d_addr, d_we, d_wdata})));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  // READ_LATENCY=1 instance
  logic        if_req, if_gnt, if_rvalid, d_req, d_gnt, d_rvalid;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  d_we, mem_we;

  // READ_LATENCY=3 instance
  logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_gnt, b_d_rvalid;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_d_we, b_mem_we;

  logic [1:0]  exp_g [10];
  int          last_g;
  int          n;

  always #5 clk = ~clk;

  mem_port_arbiter #(.READ_LATENCY(1), .MAX_WAIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.READ_LATENCY(3), .MAX_WAIT(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_addr(b_d_addr), .d_we(b_d_we), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 10; i++) exp_g[i] = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
    for (int i = 0; i < 10; i++) exp_g[i] = (i % 5 == 4) ? 2'b10 : 2'b01;
`endif
    rst_n = 1'b0;
    if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_we = 0; d_wdata = 0; mem_rdata = 0;
    b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_addr = 0; b_d_we = 0; b_d_wdata = 0;
    b_mem_rdata = 32'hCAFE_F00D;
    #12;
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_we", {28'h0, mem_we}, 32'h0);
    chk("rst ctl", {28'h0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'h0);
    chk("rst rdata", if_rdata | d_rdata, 32'h0);
    nxt();
    rst_n = 1'b1;

    // Single IF read
    nxt();
    if_req = 1; if_addr = 32'h0000_0100; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("if rd gnt", {30'h0, if_gnt, d_gnt}, 32'h2);
    nxt();
    if_req = 0;
    #1;
    chk("if rd mem_addr", mem_addr, 32'h100);
    chk("if rd T+1 rvalid", {31'h0, if_rvalid}, 32'h0);
    chk("if rd mem_we", {28'h0, mem_we}, 32'h0);
    nxt();
    chk("if rd T+2 rvalid", {31'h0, if_rvalid}, 32'h1);
    chk("if rd T+2 rdata", if_rdata, 32'hDEAD_BEEF);
    nxt();
    chk("if rd T+3 rvalid", {31'h0, if_rvalid}, 32'h0);
    chk("if rd T+3 rdata", if_rdata, 32'h0);

    // D store
    nxt();
    d_req = 1; d_addr = 32'h20; d_we = 4'b0011; d_wdata = 32'h1234_5678;
    #1;
    chk("st gnt", {30'h0, if_gnt, d_gnt}, 32'h1);
    nxt();
    d_req = 0; d_we = 0;
    #1;
    chk("st T+1 mem_we", {28'h0, mem_we}, 32'h3);
    chk("st T+1 mem_addr", mem_addr, 32'h20);
    chk("st T+1 mem_wdata", mem_wdata, 32'h1234_5678);
    chk("st T+1 d_rvalid", {31'h0, d_rvalid}, 32'h1);
    chk("st T+1 d_rdata", d_rdata, 32'h0);
    nxt();
    chk("st T+2 mem_we", {28'h0, mem_we}, 32'h0);
    chk("st T+2 d_rvalid", {31'h0, d_rvalid}, 32'h0);

    // Both requesting continuously: grant order and 3-cycle read spacing
    nxt();
    if_req = 1; if_addr = 32'h180; d_req = 1; d_addr = 32'h80; d_we = 0;
    #1;
    last_g = cyc;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      while (!(if_gnt || d_gnt) && n < 8) begin
        nxt();
        #1;
        n++;
      end
      chk($sformatf("arb grant %0d", k), {30'h0, if_gnt, d_gnt}, {30'h0, exp_g[k]});
      if (k > 0) chk($sformatf("arb gap %0d", k), cyc - last_g, 3);
      last_g = cyc;
      nxt();
    end
    if_req = 0; d_req = 0;
    repeat (3) nxt();

    // Reset during WAIT of an IF read (READ_LATENCY=3)
    nxt();
    b_if_req = 1; b_if_addr = 32'h300;
    #1;
    chk("rstw gnt", {31'h0, b_if_gnt}, 32'h1);
    nxt();
    b_if_req = 0;
    #1;
    chk("rstw mem_addr", b_mem_addr, 32'h300);
    nxt();
    chk("rstw wait rvalid", {31'h0, b_if_rvalid}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rstw async mem_addr", b_mem_addr, 32'h0);
    chk("rstw async mem_addr dut1", mem_addr, 32'h0);
    chk("rstw async mem_we", {28'h0, b_mem_we}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      nxt();
      chk("rstw held rvalid", {31'h0, b_if_rvalid}, 32'h0);
    end
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("rstw after rvalid", {31'h0, b_if_rvalid}, 32'h0);
    end

    // D load at READ_LATENCY=3 with a new request raised during WAIT
    nxt();
    b_d_req = 1; b_d_addr = 32'h40; b_d_we = 0;
    #1;
    chk("ld3 T gnt", {31'h0, b_d_gnt}, 32'h1);
    nxt();
    b_d_req = 0;
    #1;
    chk("ld3 T+1 mem_addr", b_mem_addr, 32'h40);
    chk("ld3 T+1 rvalid", {31'h0, b_d_rvalid}, 32'h0);
    nxt();
    b_d_req = 1; b_d_addr = 32'h44;
    #1;
    chk("ld3 T+2 gnt/rvalid", {30'h0, b_d_gnt, b_d_rvalid}, 32'h0);
    nxt();
    chk("ld3 T+3 gnt/rvalid", {30'h0, b_d_gnt, b_d_rvalid}, 32'h0);
    nxt();
    chk("ld3 T+4 gnt/rvalid", {30'h0, b_d_gnt, b_d_rvalid}, 32'h1);
    chk("ld3 T+4 rdata", b_d_rdata, 32'hCAFE_F00D);
    nxt();
    chk("ld3 T+5 gnt/rvalid", {30'h0, b_d_gnt, b_d_rvalid}, 32'h2);
    chk("ld3 T+5 rdata", b_d_rdata, 32'h0);
    nxt();
    b_d_req = 0;
    repeat (6) nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
